// File: rtl/shot_launcher.sv
// Shot launcher: turns fire-key presses into a held shootStart, tracks ammo and cooldown,
// and requests flight termination on hit, out-of-bounds or flight timeout.
module shot_launcher #(
  parameter int MAX_AMMO           = 8,
  parameter int COOLDOWN_FRAMES    = 15,
  parameter int ARM_TIMEOUT_FRAMES = 2,
  parameter int FLIGHT_MAX_FRAMES  = 60,
  parameter int X_MAX              = 639,
  parameter int Y_MAX              = 479
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               fireKey,
  input  logic               ammoRefill,
  input  logic               hitDetected,
  input  logic               shootEnable,
  input  logic signed [10:0] shotTopLeftX,
  input  logic signed [10:0] shotTopLeftY,
  output logic               shootStart,
  output logic               shootCollision,
  output logic [3:0]         ammoCount,
  output logic               launcherReady
);

  typedef enum logic [2:0] {IDLE, ARM, FLIGHT, TERM, COOLDOWN} state_t;

  localparam logic [3:0]         AMMO_FULL  = 4'(MAX_AMMO);
  localparam logic [7:0]         COOL_LIM   = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0]         ARM_LIM    = 8'(ARM_TIMEOUT_FRAMES);
  localparam logic [7:0]         FLIGHT_LIM = 8'(FLIGHT_MAX_FRAMES);
  localparam logic signed [10:0] X_LIM      = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM      = 11'(Y_MAX);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] ammo_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  state_t     state, state_n;
  logic       start_n, coll_n;
  logic [3:0] ammo_n;
  logic [7:0] cnt, cnt_n, cnt_tick;
  logic       fireKey_d;
  logic       fireRise;
  logic       outOfBounds;

  assign fireRise      = fireKey & ~fireKey_d;
  assign launcherReady = (state == IDLE) && (ammoCount != 4'd0);
  assign cnt_tick      = startOfFrame ? sat_inc(cnt) : cnt;

  // Signed compares so that a shot drifting past the top/left edge reads as negative.
  assign outOfBounds = (shotTopLeftX < 11'sd0) || (shotTopLeftX > X_LIM) ||
                       (shotTopLeftY < 11'sd0) || (shotTopLeftY > Y_LIM);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      shootStart     <= 1'b0;
      shootCollision <= 1'b0;
      ammoCount      <= AMMO_FULL;
      cnt            <= 8'd0;
      fireKey_d      <= 1'b0;
    end else begin
      state          <= state_n;
      shootStart     <= start_n;
      shootCollision <= coll_n;
      ammoCount      <= ammo_n;
      cnt            <= cnt_n;
      fireKey_d      <= fireKey;
    end
  end

  always_comb begin
    state_n = state;
    start_n = shootStart;
    coll_n  = shootCollision;
    ammo_n  = ammoCount;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (fireRise && (ammoCount != 4'd0)) begin
          state_n = ARM;
          start_n = 1'b1;
          ammo_n  = ammo_dec(ammoCount);
          cnt_n   = 8'd0;
        end
      end
      ARM: begin
        if (shootEnable) begin
          state_n = FLIGHT;
          cnt_n   = 8'd0;
        end else if (cnt_tick >= ARM_LIM) begin
          state_n = TERM;
          coll_n  = 1'b1;
          cnt_n   = cnt_tick;
        end else begin
          cnt_n = cnt_tick;
        end
      end
      FLIGHT: begin
        cnt_n = cnt_tick;
        // A dropped shootEnable is an external kill; it still passes through TERM.
        if (!shootEnable || hitDetected || outOfBounds || (cnt_tick >= FLIGHT_LIM)) begin
          state_n = TERM;
          coll_n  = 1'b1;
        end
      end
      TERM: begin
        if (!shootEnable) begin
          state_n = COOLDOWN;
          start_n = 1'b0;
          coll_n  = 1'b0;
          cnt_n   = 8'd0;
        end
      end
      COOLDOWN: begin
        cnt_n = cnt_tick;
        if (cnt_tick >= COOL_LIM) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        start_n = 1'b0;
        coll_n  = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase
    // Refill overrides any decrement in the same clock.
    if (ammoRefill) ammo_n = AMMO_FULL;
  end

endmodule

// File: tb/tb_shot_launcher.sv
// Directed bench for shot_launcher: launch, termination causes, cooldown, ammo and reset.
module tb_shot_launcher;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               fireKey;
  logic               ammoRefill;
  logic               hitDetected;
  logic               shootEnable;
  logic signed [10:0] shotTopLeftX;
  logic signed [10:0] shotTopLeftY;
  logic               shootStart;
  logic               shootCollision;
  logic [3:0]         ammoCount;
  logic               launcherReady;

  int checks = 0;
  int errors = 0;

  shot_launcher dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .fireKey        (fireKey),
    .ammoRefill     (ammoRefill),
    .hitDetected    (hitDetected),
    .shootEnable    (shootEnable),
    .shotTopLeftX   (shotTopLeftX),
    .shotTopLeftY   (shotTopLeftY),
    .shootStart     (shootStart),
    .shootCollision (shootCollision),
    .ammoCount      (ammoCount),
    .launcherReady  (launcherReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic launch();
    fireKey = 1'b1;
    tick();
    fireKey = 1'b0;
  endtask

  initial begin
    resetN       = 1'b1;
    startOfFrame = 1'b0;
    fireKey      = 1'b0;
    ammoRefill   = 1'b0;
    hitDetected  = 1'b0;
    shootEnable  = 1'b0;
    shotTopLeftX = 11'sd100;
    shotTopLeftY = 11'sd100;
    #2 resetN = 1'b0;
    #1;
    check("rst_start", shootStart, 0);
    check("rst_coll", shootCollision, 0);
    check("rst_ammo", ammoCount, 8);
    check("rst_ready", launcherReady, 1);
    tick();
    tick();
    resetN = 1'b1;
    tick();

    // Launch, then a held key must not relaunch
    fireKey = 1'b1;
    tick();
    check("t1_start", shootStart, 1);
    check("t1_ammo", ammoCount, 7);
    check("t1_ready", launcherReady, 0);
    shootEnable = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check("t1_hold_ammo", ammoCount, 7);
    check("t1_hold_start", shootStart, 1);
    check("t1_hold_coll", shootCollision, 0);

    // X past right edge terminates the flight
    shotTopLeftX = 11'sd640;
    tick();
    check("t2_coll", shootCollision, 1);
    check("t2_term_start", shootStart, 1);
    shotTopLeftX = 11'sd100;
    shootEnable  = 1'b0;
    tick();
    check("t2_start_off", shootStart, 0);
    check("t2_coll_off", shootCollision, 0);
    frames(14);
    check("t2_cool14_ready", launcherReady, 0);
    frames(1);
    check("t2_cool15_ready", launcherReady, 1);
    fireKey = 1'b0;
    tick();
    check("t2_no_relaunch", shootStart, 0);

    // ARM timeout without shootEnable
    launch();
    check("t3_ammo", ammoCount, 6);
    frames(1);
    check("t3_arm1_coll", shootCollision, 0);
    check("t3_arm1_start", shootStart, 1);
    frames(1);
    check("t3_term_coll", shootCollision, 1);
    check("t3_term_start", shootStart, 1);
    tick();
    check("t3_exit_coll", shootCollision, 0);
    check("t3_exit_start", shootStart, 0);
    check("t3_ammo_kept", ammoCount, 6);
    frames(15);
    check("t3_ready", launcherReady, 1);

    // Refill, drain all ammo through complete flights
    ammoRefill = 1'b1;
    tick();
    ammoRefill = 1'b0;
    check("t4_refill0", ammoCount, 8);
    for (int i = 0; i < 8; i++) begin
      launch();
      check("t4_ammo_dec", ammoCount, 7 - i);
      shootEnable = 1'b1;
      tick();
      hitDetected = 1'b1;
      tick();
      check("t4_hit_coll", shootCollision, 1);
      hitDetected = 1'b0;
      shootEnable = 1'b0;
      tick();
      frames(15);
    end
    check("t4_empty_ammo", ammoCount, 0);
    check("t4_empty_ready", launcherReady, 0);
    launch();
    check("t4_ignored_start", shootStart, 0);
    check("t4_ignored_ammo", ammoCount, 0);
    ammoRefill = 1'b1;
    tick();
    ammoRefill = 1'b0;
    check("t4_refill_ammo", ammoCount, 8);
    check("t4_refill_ready", launcherReady, 1);

    // Negative Y terminates
    launch();
    shootEnable = 1'b1;
    tick();
    check("t5_flight_coll", shootCollision, 0);
    shotTopLeftY = -11'sd1;
    tick();
    check("t5_negy_coll", shootCollision, 1);
    shotTopLeftY = 11'sd100;
    shootEnable  = 1'b0;
    tick();
    frames(15);

    // At the legal corner nothing fires until the flight times out
    launch();
    check("t5_ammo", ammoCount, 6);
    shootEnable  = 1'b1;
    shotTopLeftX = 11'sd639;
    shotTopLeftY = 11'sd479;
    tick();
    frames(59);
    check("t5_f59_coll", shootCollision, 0);
    frames(1);
    check("t5_f60_coll", shootCollision, 1);
    shotTopLeftX = 11'sd100;
    shotTopLeftY = 11'sd100;
    shootEnable  = 1'b0;
    tick();
    frames(15);

    // Refill coincident with launch, then async reset mid-flight
    fireKey    = 1'b1;
    ammoRefill = 1'b1;
    tick();
    fireKey    = 1'b0;
    ammoRefill = 1'b0;
    check("t6_launch_start", shootStart, 1);
    check("t6_refill_wins", ammoCount, 8);
    shootEnable = 1'b1;
    tick();
    hitDetected = 1'b1;
    tick();
    check("t6_pre_rst_coll", shootCollision, 1);
    #2 resetN = 1'b0;
    #1;
    check("t6_rst_start", shootStart, 0);
    check("t6_rst_coll", shootCollision, 0);
    check("t6_rst_ammo", ammoCount, 8);
    hitDetected = 1'b0;
    shootEnable = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
    check("t6_release_start", shootStart, 0);
    check("t6_release_coll", shootCollision, 0);
    check("t6_release_ready", launcherReady, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_launcher.md
Name: shot_launcher

Overview:
- Initiator/terminator for the shot trajectory generator.
- Converts player fire-key presses into a held shootStart level and tracks ammo and cooldown.
- Monitors the returned shot position and hit indication, and issues shootCollision to end a flight.
- Sits between the keypad interface, the collision detector and the shot trajectory block.

Parameters:
MAX_AMMO, 8, shots available after reset or refill (1..15)
COOLDOWN_FRAMES, 15, frames after a flight ends before next launch permitted
ARM_TIMEOUT_FRAMES, 2, frames to wait for shootEnable after raising shootStart
FLIGHT_MAX_FRAMES, 60, frames after which a live shot is force-terminated
X_MAX, 639, rightmost legal pixel column
Y_MAX, 479, bottom legal pixel row

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame (30Hz)
fireKey  in  1  debounced fire key level, active high
ammoRefill  in  1  one-clk pulse; reload ammo to MAX_AMMO
hitDetected  in  1  collision detector: shot overlaps object/wall (level)
shootEnable  in  1  shot block: shot visible/alive
shotTopLeftX  in  11 signed  shot top-left X, pixels
shotTopLeftY  in  11 signed  shot top-left Y, pixels
shootStart  out  1  level; high while a launch/flight is in progress
shootCollision  out  1  level; termination request to shot block
ammoCount  out  4  remaining shots
launcherReady  out  1  high when a fire press would launch

Behaviour:
- Async reset: state=IDLE, shootStart=0, shootCollision=0, ammoCount=MAX_AMMO, frame counter=0, fire-edge register=0. launcherReady is combinational.
- Fire edge: fireRise = fireKey & ~fireKey_d (1 clk). A held key launches at most once.
- launcherReady = (state==IDLE) & (ammoCount!=0).
- IDLE:
  - fireRise & ammoCount!=0 -> ARM next clk.
  - In the same clk: shootStart<=1, ammoCount<=ammoCount-1, frame counter<=0.
  - fireRise with ammoCount==0 -> ignored.
- ARM:
  - shootEnable==1 -> FLIGHT, counter<=0.
  - Else count startOfFrame pulses. When the count reaches ARM_TIMEOUT_FRAMES -> TERM. The ammo is not refunded.
- FLIGHT:
  - Counter increments on each startOfFrame.
  - Terminate when any of the following holds: hitDetected; shotTopLeftX<0; shotTopLeftX>X_MAX; shotTopLeftY<0; shotTopLeftY>Y_MAX; counter==FLIGHT_MAX_FRAMES.
  - All comparisons are signed 11-bit.
  - On terminate -> TERM with shootCollision<=1.
  - shootEnable falling while in FLIGHT -> TERM directly (external kill).
- TERM:
  - shootCollision held high and shootStart held high until shootEnable==0.
  - Then shootCollision<=0, shootStart<=0, counter<=0 -> COOLDOWN.
  - Minimum one clk in TERM.
- COOLDOWN:
  - Counter increments on startOfFrame. At COOLDOWN_FRAMES -> IDLE.
  - COOLDOWN_FRAMES=0 -> IDLE the next clk.
  - fireRise in COOLDOWN is dropped, not queued.
- ammoRefill:
  - Loads MAX_AMMO in any state.
  - Same clk as a launch decrement: refill wins, result is MAX_AMMO.
- Saturation: ammoCount never wraps below 0. Decrement occurs only when ammoCount!=0.
- Counters are 8-bit and saturate at 255.
- shootCollision is asserted only in TERM; it is never high in IDLE/ARM/COOLDOWN.
- Reset mid-flight: all outputs return to reset values immediately (async). No pulse is emitted on release.

Test Plan:
1. Reset, fireKey rises -> next clk shootStart=1, ammoCount=7. Assert shootEnable -> FLIGHT. Hold fireKey high 100 clks -> no second launch.
2. FLIGHT, drive shotTopLeftX=640 -> shootCollision=1 next clk. Drop shootEnable -> shootStart=0, shootCollision=0. After 15 startOfFrame pulses -> launcherReady=1.
3. ARM, never assert shootEnable, 2 startOfFrame pulses -> TERM. shootCollision=1 until shootEnable=0 (already 0: exit next clk). ammoCount stays decremented.
4. Fire 8 complete flights -> ammoCount=0, launcherReady=0. Next fireRise is ignored. ammoRefill pulse -> ammoCount=8.
5. Negative coordinate shotTopLeftY=-1 in FLIGHT -> termination. Separately, no boundary violation and 60 frames elapse -> forced termination.
6. ammoRefill coincident with the launch clk -> ammoCount=8. Assert resetN=0 mid-FLIGHT -> shootStart=0, shootCollision=0, ammoCount=8 immediately.
